// File: rtl/ssi_tx.sv
// rtl/ssi_tx.sv - master-mode I2S-style serial transmitter with double-buffered left/right words
module ssi_tx #(
    parameter int WIDTH = 16,
    parameter int DIV_W = 8
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] sclk_div,
    input  logic [WIDTH-1:0] left_data,
    input  logic             wr_left,
    input  logic [WIDTH-1:0] right_data,
    input  logic             wr_right,
    output logic             ready_l,
    output logic             ready_r,
    output logic             sclk,
    output logic             ws,
    output logic             sdata,
    output logic             frame,
    output logic             underrun
);
    localparam int FRAME = 2 * WIDTH;
    localparam int SW = $clog2(FRAME);
    localparam logic [SW-1:0] SLOT_LAST = SW'(FRAME - 1);
    localparam logic [SW-1:0] SLOT_WS   = SW'(WIDTH - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [SW-1:0]    slot;
    logic [SW-1:0]    slot_next;
    logic [FRAME-2:0] shifter;
    logic [WIDTH-1:0] left_hold;
    logic [WIDTH-1:0] right_hold;
    logic [WIDTH-1:0] left_load;
    logic [WIDTH-1:0] right_load;

    // an empty holding register contributes a silent (all-zero) half frame
    always_comb begin
        slot_next  = (slot == SLOT_LAST) ? '0 : slot + 1'b1;
        left_load  = ready_l ? '0 : left_hold;
        right_load = ready_r ? '0 : right_hold;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            div_cnt    <= '0;
            sclk       <= 1'b0;
            slot       <= SLOT_LAST;
            ws         <= 1'b0;
            sdata      <= 1'b0;
            shifter    <= '0;
            frame      <= 1'b0;
            underrun   <= 1'b0;
            ready_l    <= 1'b1;
            ready_r    <= 1'b1;
            left_hold  <= '0;
            right_hold <= '0;
        end else begin
            frame    <= 1'b0;
            underrun <= 1'b0;
            if (!enable) begin
                div_cnt <= '0;
                sclk    <= 1'b0;
                slot    <= SLOT_LAST;
                ws      <= 1'b0;
                sdata   <= 1'b0;
                shifter <= '0;
            end else if (div_cnt == sclk_div) begin
                div_cnt <= '0;
                sclk    <= ~sclk;
                if (sclk) begin
                    slot <= slot_next;
                    // word select leads the data by one slot
                    ws   <= (slot_next >= SLOT_WS) && (slot_next != SLOT_LAST);
                    if (slot_next == '0) begin
                        shifter  <= {left_load[WIDTH-2:0], right_load};
                        sdata    <= left_load[WIDTH-1];
                        frame    <= 1'b1;
                        underrun <= ready_l | ready_r;
                        ready_l  <= 1'b1;
                        ready_r  <= 1'b1;
                    end else begin
                        shifter <= {shifter[FRAME-3:0], 1'b0};
                        sdata   <= shifter[FRAME-2];
                    end
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            // writes come after the load so a same-cycle write lands for the next frame
            if (wr_left) begin
                left_hold <= left_data;
                ready_l   <= 1'b0;
            end
            if (wr_right) begin
                right_hold <= right_data;
                ready_r    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ssi_tx.sv
// tb/tb_ssi_tx.sv - randomized self-checking bench for ssi_tx against a cycle-count reference model
module tb_ssi_tx;
    logic        sys_clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  sclk_div = 8'd0;
    logic [15:0] left_data = 16'h0;
    logic [15:0] right_data = 16'h0;
    logic        wr_left = 1'b0;
    logic        wr_right = 1'b0;
    logic        ready_l, ready_r, sclk, ws, sdata, frame, underrun;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_lh = 16'h0, m_rh = 16'h0;
    bit          m_lv = 0, m_rv = 0;
    bit          m_sclk = 0;
    int          m_cyc = 0, m_slot = 31;
    logic [31:0] m_word = 32'h0, m_cap = 32'h0, m_last_frame = 'x;
    int          m_nbits = 0, m_frames = 0;
    int          cyc = 0, last_load_cyc = 0, load_interval = 0, last_fall = 0, fall_interval = 0;

    ssi_tx #(.WIDTH(16), .DIV_W(8)) dut (
        .sys_clk(sys_clk), .reset(reset), .enable(enable), .sclk_div(sclk_div),
        .left_data(left_data), .wr_left(wr_left), .right_data(right_data), .wr_right(wr_right),
        .ready_l(ready_l), .ready_r(ready_r), .sclk(sclk), .ws(ws), .sdata(sdata),
        .frame(frame), .underrun(underrun)
    );

    always #5 sys_clk = ~sys_clk;

    // advance one sys_clk cycle, update the reference model and compare every output
    task automatic tick();
        bit p_rst, p_en, p_wl, p_wr, exp_frame, exp_under, fell, exp_ws;
        logic [15:0] p_ld, p_rd;
        int p_div;
        p_rst = reset; p_en = enable; p_wl = wr_left; p_wr = wr_right;
        p_ld = left_data; p_rd = right_data; p_div = int'(sclk_div);
        @(posedge sys_clk);
        @(negedge sys_clk);
        cyc++;
        exp_frame = 0; exp_under = 0; fell = 0;
        if (p_rst) begin
            m_lh = 16'h0; m_rh = 16'h0; m_lv = 0; m_rv = 0;
            m_cyc = 0; m_slot = 31; m_word = 32'h0; m_sclk = 0; m_nbits = 0;
        end else begin
            if (!p_en) begin
                m_cyc = 0; m_slot = 31; m_word = 32'h0; m_sclk = 0; m_nbits = 0;
            end else begin
                m_cyc++;
                if (m_cyc % (p_div + 1) == 0) begin
                    m_sclk = !m_sclk;
                    if (!m_sclk) begin
                        fell = 1;
                        m_slot = (m_slot + 1) % 32;
                        if (m_slot == 0) begin
                            m_word = {m_lv ? m_lh : 16'h0, m_rv ? m_rh : 16'h0};
                            exp_frame = 1;
                            exp_under = !(m_lv && m_rv);
                            m_lv = 0; m_rv = 0;
                        end
                    end
                end
            end
            if (p_wl) begin m_lh = p_ld; m_lv = 1; end
            if (p_wr) begin m_rh = p_rd; m_rv = 1; end
        end
        wr_left = 1'b0; wr_right = 1'b0;
        exp_ws = ((m_slot + 1) % 32) >= 16;
        checks++; if (sclk !== m_sclk) begin errors++; $display("FAIL sclk: got %b want %b cyc %0d", sclk, m_sclk, cyc); end
        checks++; if (ws !== exp_ws) begin errors++; $display("FAIL ws: got %b want %b slot %0d cyc %0d", ws, exp_ws, m_slot, cyc); end
        checks++; if (sdata !== m_word[31-m_slot]) begin errors++; $display("FAIL sdata: got %b want %b slot %0d cyc %0d", sdata, m_word[31-m_slot], m_slot, cyc); end
        checks++; if (frame !== exp_frame) begin errors++; $display("FAIL frame: got %b want %b cyc %0d", frame, exp_frame, cyc); end
        checks++; if (underrun !== exp_under) begin errors++; $display("FAIL underrun: got %b want %b cyc %0d", underrun, exp_under, cyc); end
        checks++; if (ready_l !== !m_lv) begin errors++; $display("FAIL ready_l: got %b want %b cyc %0d", ready_l, !m_lv, cyc); end
        checks++; if (ready_r !== !m_rv) begin errors++; $display("FAIL ready_r: got %b want %b cyc %0d", ready_r, !m_rv, cyc); end
        if (fell) begin
            if (exp_frame) begin
                m_last_frame = (m_nbits == 32) ? m_cap : 'x;
                m_cap = 32'h0; m_nbits = 0; m_frames++;
                load_interval = cyc - last_load_cyc; last_load_cyc = cyc;
            end
            m_cap = {m_cap[30:0], sdata}; m_nbits++;
            fall_interval = cyc - last_fall; last_fall = cyc;
        end
    endtask

    task automatic run_loads(input int n, input int budget);
        int goal = m_frames + n;
        int k = 0;
        while (m_frames < goal && k < budget) begin tick(); k++; end
        checks++;
        if (m_frames < goal) begin errors++; $display("FAIL load_timeout: loads %0d want %0d", m_frames, goal); end
    endtask

    task automatic write_pair(input logic [15:0] l, input logic [15:0] r);
        left_data = l; wr_left = 1'b1; tick();
        right_data = r; wr_right = 1'b1; tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; left_data = 16'hFFFF; wr_left = 1'b1; tick();
        reset = 1'b0;
        repeat (10) tick();
        checks++;
        if ({sclk, ws, sdata, frame, underrun, ready_l, ready_r} !== 7'b0000011) begin
            errors++; $display("FAIL reset_idle: got %b want 0000011", {sclk, ws, sdata, frame, underrun, ready_l, ready_r});
        end
    endtask

    task automatic test_basic();
        int c0;
        sclk_div = 8'd1;
        write_pair(16'hA5C3, 16'h0F0F);
        c0 = cyc; enable = 1'b1;
        run_loads(1, 20);
        checks++; if (last_load_cyc - c0 !== 4) begin errors++; $display("FAIL first_load_latency: got %0d want 4", last_load_cyc - c0); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL basic_underrun: got %b want 0", underrun); end
        run_loads(1, 200);
        checks++; if (m_last_frame !== 32'hA5C30F0F) begin errors++; $display("FAIL basic_bits: got %h want a5c30f0f", m_last_frame); end
        checks++; if (fall_interval !== 4) begin errors++; $display("FAIL basic_period: got %0d want 4", fall_interval); end
    endtask

    task automatic test_underrun();
        enable = 1'b0; tick();
        left_data = 16'hFFFF; wr_left = 1'b1; tick();
        enable = 1'b1;
        run_loads(1, 20);
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_pulse: got %b want 1", underrun); end
        checks++; if (ready_l !== 1'b1) begin errors++; $display("FAIL underrun_ready_l: got %b want 1", ready_l); end
        tick();
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_width: got %b want 0", underrun); end
        run_loads(1, 200);
        checks++; if (m_last_frame !== 32'hFFFF0000) begin errors++; $display("FAIL underrun_bits: got %h want ffff0000", m_last_frame); end
    endtask

    task automatic test_write_at_load();
        logic [15:0] l1, l2;
        int d;
        l1 = 16'($urandom); l2 = 16'($urandom); d = $urandom_range(0, 3);
        enable = 1'b0; sclk_div = 8'(d); tick();
        write_pair(l1, 16'h8001);
        enable = 1'b1;
        repeat (2 * (d + 1) - 1) tick();
        right_data = 16'h1234; wr_right = 1'b1; tick();
        checks++; if (frame !== 1'b1) begin errors++; $display("FAIL wal_frame: got %b want 1", frame); end
        checks++; if (ready_r !== 1'b0) begin errors++; $display("FAIL wal_ready_r: got %b want 0", ready_r); end
        left_data = l2; wr_left = 1'b1; tick();
        run_loads(1, 400);
        checks++; if (m_last_frame !== {l1, 16'h8001}) begin errors++; $display("FAIL wal_frame1: got %h want %h", m_last_frame, {l1, 16'h8001}); end
        run_loads(1, 400);
        checks++; if (m_last_frame !== {l2, 16'h1234}) begin errors++; $display("FAIL wal_frame2: got %h want %h", m_last_frame, {l2, 16'h1234}); end
    endtask

    task automatic test_abort();
        logic [15:0] la, ra, lb, rb;
        int k = 0;
        la = 16'($urandom); ra = 16'($urandom); lb = 16'($urandom); rb = 16'($urandom);
        enable = 1'b0; sclk_div = 8'd1; tick();
        write_pair(la, ra);
        enable = 1'b1;
        run_loads(1, 20);
        while (m_slot != 9 && k < 200) begin tick(); k++; end
        checks++; if (m_slot != 9) begin errors++; $display("FAIL abort_reach_slot9: slot %0d want 9", m_slot); end
        enable = 1'b0; tick();
        checks++;
        if ({sclk, ws, sdata} !== 3'b000) begin errors++; $display("FAIL abort_idle: got %b want 000", {sclk, ws, sdata}); end
        write_pair(lb, rb);
        enable = 1'b1;
        run_loads(1, 20);
        checks++; if (sdata !== lb[15]) begin errors++; $display("FAIL abort_msb: got %b want %b", sdata, lb[15]); end
        run_loads(1, 200);
        checks++; if (m_last_frame !== {lb, rb}) begin errors++; $display("FAIL abort_frame: got %h want %h", m_last_frame, {lb, rb}); end
    endtask

    task automatic test_div0();
        logic [15:0] l2, r2;
        l2 = 16'($urandom); r2 = 16'($urandom);
        enable = 1'b0; sclk_div = 8'd0; tick();
        write_pair(16'hA5C3, 16'h0F0F);
        enable = 1'b1;
        run_loads(1, 10);
        write_pair(l2, r2);
        run_loads(1, 100);
        checks++; if (m_last_frame !== 32'hA5C30F0F) begin errors++; $display("FAIL div0_bits: got %h want a5c30f0f", m_last_frame); end
        checks++; if (load_interval !== 64) begin errors++; $display("FAIL div0_frame_len: got %0d want 64", load_interval); end
        checks++; if (fall_interval !== 2) begin errors++; $display("FAIL div0_period: got %0d want 2", fall_interval); end
        run_loads(1, 100);
        checks++; if (m_last_frame !== {l2, r2}) begin errors++; $display("FAIL div0_frame2: got %h want %h", m_last_frame, {l2, r2}); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            enable = 1'b0; sclk_div = 8'($urandom_range(0, 3)); tick();
            enable = 1'b1;
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 30) == 0) begin left_data = 16'($urandom); wr_left = 1'b1; end
                if ($urandom_range(0, 30) == 0) begin right_data = 16'($urandom); wr_right = 1'b1; end
                tick();
            end
        end
        enable = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_write_at_load();
        test_abort();
        test_div0();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
